data_producer: RTL

Single-clock source stage that generates the 16-bit value stream consumed by the clock-crossing buffer on the fast clock. It runs either a Fibonacci sequence or a down-counting timer and presents each value with a same-cycle valid/full handshake. It stalls without loss while the buffer reports full.

---
 rtl/data_producer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/data_producer.sv
// data_producer: single-clock value source for the clock-crossing buffer.
// Emits a Fibonacci sequence (F0..F24). When PRODUCER_TIMER_EN is defined it
// can also emit a prescaled down-count from timer_limit to 0. Each value is
// offered with a same-cycle valid (data_1_en) that is gated combinationally by
// buffer_full, so a stalled value is held without loss.
module data_producer
`ifdef PRODUCER_TIMER_EN
  #(parameter int TIMER_DIV = 1)
`endif
(
  input  logic        clk_1,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        prog,
  input  logic [15:0] timer_limit,
  input  logic        buffer_full,
  output logic        data_1_en,
  output logic [15:0] data_1,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIB   = 2'd1,
`ifdef PRODUCER_TIMER_EN
    TIMER = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] a;
  logic [16:0] b;
  logic [16:0] fib_sum;
  logic        accept_start;
  logic        load_fib;

`ifdef PRODUCER_TIMER_EN
  localparam logic [15:0] PRE_MAX = 16'(TIMER_DIV - 1);

  logic [15:0] cnt;
  logic [15:0] pre;
  logic        load_tmr;
`else
  // Mode inputs have no effect in the Fibonacci-only build.
  logic        unused_cfg;
  assign unused_cfg = ^{prog, timer_limit};
`endif

  // A start is only honoured from a resting state, and stop always overrides it.
  assign accept_start = ((state == IDLE) || (state == DONE)) && start && !stop;

`ifdef PRODUCER_TIMER_EN
  assign load_fib = accept_start && !prog;
  assign load_tmr = accept_start &&  prog;
`else
  assign load_fib = accept_start;
`endif

  // Full 17-bit sum so the bit-16 end-of-run test sees the true carry.
  assign fib_sum = {1'b0, a} + b;

  // State register.
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and the combinational handshake toward the buffer.
  always_comb begin
    state_nxt = state;
    data_1_en = 1'b0;
    data_1    = 16'd0;
    busy      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (start) begin
`ifdef PRODUCER_TIMER_EN
          state_nxt = prog ? TIMER : FIB;
`else
          state_nxt = FIB;
`endif
        end
      end
      FIB: begin
        busy      = 1'b1;
        data_1    = a;
        data_1_en = !stop && !buffer_full;
        if (stop) begin
          state_nxt = IDLE;
        end else if (data_1_en && b[16]) begin
          state_nxt = DONE;
        end
      end
`ifdef PRODUCER_TIMER_EN
      TIMER: begin
        busy      = 1'b1;
        data_1    = cnt;
        data_1_en = !stop && !buffer_full && (pre == PRE_MAX);
        if (stop) begin
          state_nxt = IDLE;
        end else if (data_1_en && (cnt == 16'd0)) begin
          state_nxt = DONE;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Fibonacci pair: seeded on start, advanced only on an accepted transfer.
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      a <= 16'd0;
      b <= 17'd1;
    end else if (load_fib) begin
      a <= 16'd0;
      b <= 17'd1;
    end else if ((state == FIB) && data_1_en) begin
      a <= b[15:0];
      b <= fib_sum;
    end
  end

`ifdef PRODUCER_TIMER_EN
  // Down-counter and prescaler: pre saturates at PRE_MAX until the value is taken.
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 16'd0;
      pre <= 16'd0;
    end else if (load_tmr) begin
      cnt <= timer_limit;
      pre <= 16'd0;
    end else if (state == TIMER) begin
      if (data_1_en) begin
        cnt <= cnt - 16'd1;
        pre <= 16'd0;
      end else if (pre < PRE_MAX) begin
        pre <= pre + 16'd1;
      end
    end
  end
`endif

  // Sticky completion flag: set on natural entry to DONE, cleared by the next start.
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else if (accept_start) begin
      done <= 1'b0;
    end else if (busy && (state_nxt == DONE)) begin
      done <= 1'b1;
    end
  end

endmodule
